// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter:
// FSM states, port ownership and the default ROM/RAM split point.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        CPU = 1'b0,
        LDR = 1'b1
    } owner_t;

    localparam logic [10:0] ROM_TOP_DEFAULT = 11'h7F;

endpackage

// File: rtl/mem_region_decode.sv
// Address-to-region decode: addresses above ROM_TOP are RAM, and only
// RAM is writable.
module mem_region_decode
    import mem_arbiter_pkg::*;
#(
    parameter int                ADDR_W  = 11,
    parameter logic [ADDR_W-1:0] ROM_TOP = ADDR_W'(ROM_TOP_DEFAULT)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    output logic              region,
    output logic              ram_we
);

    assign region = (addr > ROM_TOP);
    assign ram_we = we & region;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one ROM/RAM pair between a CPU port and a
// message-loader port; each access is a fixed IDLE -> ACCESS -> RESP sequence.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int                ADDR_W  = 11,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] ROM_TOP = ADDR_W'(ROM_TOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              WRA,
    output logic              S,
    input  logic [DATA_W-1:0] rom_rdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rom_wr_err
);

    state_t            state_reg, state_next;
    owner_t            owner_reg, last_grant_reg, winner;
    logic              grant;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] cpu_rdata_reg, ldr_rdata_reg;
    logic              rom_wr_err_reg;
    logic              region, region_we;
    logic [DATA_W-1:0] resp_data;

    // Decoding the latched address keeps S stable between accesses.
    mem_region_decode #(
        .ADDR_W  (ADDR_W),
        .ROM_TOP (ROM_TOP)
    ) u_decode (
        .addr   (addr_reg),
        .we     (we_reg),
        .region (region),
        .ram_we (region_we)
    );

    always_comb begin
        grant  = cpu_req | ldr_req;
        winner = CPU;
        if (cpu_req && ldr_req) begin
            winner = (last_grant_reg == CPU) ? LDR : CPU;
        end else if (ldr_req) begin
            winner = LDR;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            owner_reg      <= CPU;
            last_grant_reg <= LDR;
        end else if (state_reg == IDLE && grant) begin
            addr_reg       <= (winner == LDR) ? ldr_addr  : cpu_addr;
            we_reg         <= (winner == LDR) ? ldr_we    : cpu_we;
            wdata_reg      <= (winner == LDR) ? ldr_wdata : cpu_wdata;
            owner_reg      <= winner;
            last_grant_reg <= winner;
        end
    end

    assign resp_data = region ? ram_rdata : rom_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_reg <= '0;
            ldr_rdata_reg <= '0;
        end else if (state_reg == RESP) begin
            if (owner_reg == CPU) begin
                cpu_rdata_reg <= resp_data;
            end else begin
                ldr_rdata_reg <= resp_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_wr_err_reg <= 1'b0;
        end else if (state_reg == ACCESS && we_reg && !region) begin
            rom_wr_err_reg <= 1'b1;
        end
    end

    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;
    assign S          = region;
    assign WRA        = (state_reg == ACCESS) & region_we;
    assign rom_wr_err = rom_wr_err_reg;

    assign cpu_ack = (state_reg == RESP) && (owner_reg == CPU);
    assign ldr_ack = (state_reg == RESP) && (owner_reg == LDR);

    // Memory data only arrives in RESP, so the ack cycle bypasses the holding
    // register; afterwards the register keeps the value until the next RESP.
    assign cpu_rdata = cpu_ack ? resp_data : cpu_rdata_reg;
    assign ldr_rdata = ldr_ack ? resp_data : ldr_rdata_reg;

endmodule
